// File: rtl/load_hazard_ctrl.sv
// load_hazard_ctrl: load-use hazard detector that stalls F/D and bubbles E for LOAD_LAT cycles, with decode-kill abort.
// Optional HAZARD_STALL_CNT_EN adds a saturating cumulative stall-cycle counter on stall_cnt.
module load_hazard_ctrl #(
  parameter int WIDTH    = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] RegS1D,
  input  logic [WIDTH-1:0] RegS2D,
  input  logic             UseS1D,
  input  logic             UseS2D,
  input  logic [WIDTH-1:0] WriteRegE,
  input  logic             MeMtoRegE,
  input  logic             RegWriteE,
  input  logic             KillD,
  output logic             lwstall,
  output logic             FlushE
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);
  localparam int RW = $clog2(LOAD_LAT + 1);
  typedef enum logic {IDLE, STALL} state_t;
  state_t        state_q, state_d;
  logic [RW-1:0] rem_q, rem_d;
  logic          hit;
  assign hit = MeMtoRegE & RegWriteE & (WriteRegE != '0) &
               ((UseS1D & (RegS1D == WriteRegE)) | (UseS2D & (RegS2D == WriteRegE)));
  // rst gates the outputs directly so they drop the instant reset asserts
  assign lwstall = rst & ~KillD & ((state_q == STALL) | hit);
  assign FlushE  = rst & (lwstall | KillD);
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (state_q == STALL) begin
      state_d = (KillD || rem_q == RW'(1)) ? IDLE : STALL;
      rem_d   = KillD ? '0 : rem_q - RW'(1);
    end else if (lwstall && LOAD_LAT > 1) begin
      state_d = STALL;
      rem_d   = RW'(LOAD_LAT - 1);
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end
`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else if (lwstall && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
  end
  assign stall_cnt = cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = |CNT_W;
`endif
endmodule
